// File: rtl/cmos_video_tx_pkg.sv
// Shared types and constants for the CMOS-style video transmitter.
package cmos_video_tx_pkg;

  localparam int unsigned CNT_W = 12;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FV_LEAD,
    ST_LINE_ACTIVE,
    ST_LINE_BLANK,
    ST_FV_TRAIL,
    ST_FRAME_BLANK
  } state_t;

  typedef enum logic [1:0] {
    PAT_STREAM = 2'd0,
    PAT_HRAMP  = 2'd1,
    PAT_VRAMP  = 2'd2,
    PAT_CHECK  = 2'd3
  } pat_t;

  function automatic int unsigned max4(input int unsigned a, input int unsigned b,
                                       input int unsigned c, input int unsigned d);
    int unsigned m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    if (d > m) m = d;
    return m;
  endfunction

endpackage

// File: rtl/cmos_pattern_gen.sv
// Combinational pixel source: selects the stream pixel or a test pattern from col/row.
module cmos_pattern_gen
  import cmos_video_tx_pkg::*;
(
  input  logic [CNT_W-1:0] i_col,
  input  logic [CNT_W-1:0] i_row,
  input  pat_t             i_pat,
  input  logic [9:0]       i_stream,
  output logic [9:0]       o_pixel
);

  logic w_unused;
  assign w_unused = ^{i_col[CNT_W-1:10], i_row[CNT_W-1:10]};

  always_comb begin
    o_pixel = i_stream;
    case (i_pat)
      PAT_STREAM: o_pixel = i_stream;
      PAT_HRAMP:  o_pixel = i_col[9:0];
      PAT_VRAMP:  o_pixel = i_row[9:0];
      PAT_CHECK:  o_pixel = (i_col[3] ^ i_row[3]) ? '1 : '0;
      default:    o_pixel = i_stream;
    endcase
  end

endmodule

// File: rtl/cmos_video_tx.sv
// fv/lv/pixel timing generator; all outputs registered from the next-state decode.
module cmos_video_tx
  import cmos_video_tx_pkg::*;
#(
  parameter int unsigned H_ACTIVE = 640,
  parameter int unsigned V_ACTIVE = 480,
  parameter int unsigned H_BLANK  = 160,
  parameter int unsigned FV_LEAD  = 16,
  parameter int unsigned FV_TRAIL = 16,
  parameter int unsigned V_BLANK  = 1000
) (
  input  logic        clk_pixel,
  input  logic        reset,
  input  logic        enable,
  input  logic [1:0]  pattern_sel,
  input  logic [9:0]  s_data,
  input  logic        s_valid,
  output logic        s_ready,
  output logic        fv_o,
  output logic        lv_o,
  output logic [9:0]  pd_o,
  output logic [15:0] frame_cnt_o,
  output logic        underflow_o,
  output logic        busy_o
);

  localparam int unsigned PW = $clog2(max4(FV_LEAD, H_BLANK, FV_TRAIL, V_BLANK)) + 1;

  state_t           r_state, w_nxt_state;
  logic [PW-1:0]    r_cnt, w_nxt_cnt;
  logic [CNT_W-1:0] r_col, r_row, w_nxt_col, w_nxt_row;
  pat_t             r_pat, w_nxt_pat;
  logic             w_frame_done;
  logic             w_pre_active;
  logic [9:0]       w_stream_px, w_pixel;
  logic             r_s_ready, r_fv, r_lv, r_uf, r_busy;
  logic [9:0]       r_pd;
  logic [15:0]      r_frame_cnt;

  always_comb begin
    w_nxt_state  = r_state;
    w_nxt_cnt    = r_cnt;
    w_nxt_col    = r_col;
    w_nxt_row    = r_row;
    w_nxt_pat    = r_pat;
    w_frame_done = 1'b0;
    case (r_state)
      ST_IDLE: if (enable) begin
        w_nxt_state = ST_FV_LEAD;
        w_nxt_cnt   = '0;
        w_nxt_pat   = pat_t'(pattern_sel);
      end
      ST_FV_LEAD: if (r_cnt == PW'(FV_LEAD - 1)) begin
        w_nxt_state = ST_LINE_ACTIVE;
        w_nxt_col   = '0;
        w_nxt_row   = '0;
      end else w_nxt_cnt = r_cnt + PW'(1);
      ST_LINE_ACTIVE: if (r_col == CNT_W'(H_ACTIVE - 1)) begin
        w_nxt_cnt   = '0;
        w_nxt_state = (r_row == CNT_W'(V_ACTIVE - 1)) ? ST_FV_TRAIL : ST_LINE_BLANK;
      end else w_nxt_col = r_col + CNT_W'(1);
      ST_LINE_BLANK: if (r_cnt == PW'(H_BLANK - 1)) begin
        w_nxt_state = ST_LINE_ACTIVE;
        w_nxt_col   = '0;
        w_nxt_row   = r_row + CNT_W'(1);
      end else w_nxt_cnt = r_cnt + PW'(1);
      ST_FV_TRAIL: if (r_cnt == PW'(FV_TRAIL - 1)) begin
        w_nxt_state  = ST_FRAME_BLANK;
        w_nxt_cnt    = '0;
        w_frame_done = 1'b1;
      end else w_nxt_cnt = r_cnt + PW'(1);
      ST_FRAME_BLANK: if (r_cnt == PW'(V_BLANK - 1)) begin
        w_nxt_cnt = '0;
        if (enable) begin
          w_nxt_state = ST_FV_LEAD;
          w_nxt_pat   = pat_t'(pattern_sel);
        end else w_nxt_state = ST_IDLE;
      end else w_nxt_cnt = r_cnt + PW'(1);
      default: w_nxt_state = ST_IDLE;
    endcase
  end

  // s_ready is registered, so it must predict one state beyond the next one.
  always_comb begin
    w_pre_active = 1'b0;
    case (w_nxt_state)
      ST_FV_LEAD:     w_pre_active = (w_nxt_cnt == PW'(FV_LEAD - 1));
      ST_LINE_ACTIVE: w_pre_active = (w_nxt_col != CNT_W'(H_ACTIVE - 1));
      ST_LINE_BLANK:  w_pre_active = (w_nxt_cnt == PW'(H_BLANK - 1));
      default:        w_pre_active = 1'b0;
    endcase
  end

  assign w_stream_px = (r_s_ready && s_valid) ? s_data : '0;

  cmos_pattern_gen u_pattern_gen (
    .i_col    (w_nxt_col),
    .i_row    (w_nxt_row),
    .i_pat    (r_pat),
    .i_stream (w_stream_px),
    .o_pixel  (w_pixel)
  );

  always_ff @(posedge clk_pixel) begin
    if (reset) begin
      r_state     <= ST_IDLE;
      r_cnt       <= '0;
      r_col       <= '0;
      r_row       <= '0;
      r_pat       <= PAT_STREAM;
      r_s_ready   <= 1'b0;
      r_fv        <= 1'b0;
      r_lv        <= 1'b0;
      r_pd        <= '0;
      r_uf        <= 1'b0;
      r_busy      <= 1'b0;
      r_frame_cnt <= '0;
    end else begin
      r_state   <= w_nxt_state;
      r_cnt     <= w_nxt_cnt;
      r_col     <= w_nxt_col;
      r_row     <= w_nxt_row;
      r_pat     <= w_nxt_pat;
      r_s_ready <= w_pre_active && (w_nxt_pat == PAT_STREAM);
      r_fv      <= (w_nxt_state != ST_IDLE) && (w_nxt_state != ST_FRAME_BLANK);
      r_lv      <= (w_nxt_state == ST_LINE_ACTIVE);
      r_pd      <= (w_nxt_state == ST_LINE_ACTIVE) ? w_pixel : '0;
      r_uf      <= r_s_ready && !s_valid;
      r_busy    <= (w_nxt_state != ST_IDLE);
      if (w_frame_done) r_frame_cnt <= r_frame_cnt + 16'd1;
    end
  end

  assign s_ready     = r_s_ready;
  assign fv_o        = r_fv;
  assign lv_o        = r_lv;
  assign pd_o        = r_pd;
  assign underflow_o = r_uf;
  assign busy_o      = r_busy;
  assign frame_cnt_o = r_frame_cnt;

endmodule

// File: doc/cmos_video_tx.md
Name: cmos_video_tx

Overview:
Parallel CMOS-style video transmitter: generates fv/lv/10-bit pixel-data timing identical in form to the stream our MIPI-to-CMOS receiver delivers to the histogram logic. Pixels come from an upstream valid/ready stream or a built-in test pattern. Used to drive downstream pixel consumers (histogram, DIFF output path) without a camera, and as the source side of loopback benches.

Parameters:
H_ACTIVE, 640, pixels per line (lv_o high cycles per line), 1..4095
V_ACTIVE, 480, lines per frame, 1..4095
H_BLANK, 160, lv_o-low cycles between lines within a frame, >=1
FV_LEAD, 16, cycles fv_o high before first line's lv_o, >=1
FV_TRAIL, 16, cycles fv_o high after last line's lv_o falls, >=1
V_BLANK, 1000, cycles fv_o low between frames, >=1

Ports:
clk_pixel  in  1  pixel clock; all logic on rising edge
reset  in  1  synchronous, active-high
enable  in  1  run frames; sampled only at frame boundaries
pattern_sel  in  2  0=stream, 1=horizontal ramp, 2=vertical ramp, 3=checker
s_data  in  10  upstream pixel
s_valid  in  1  upstream pixel valid
s_ready  out  1  transmitter accepts s_data this cycle
fv_o  out  1  frame valid
lv_o  out  1  line valid
pd_o  out  10  pixel data, meaningful only when lv_o=1, else 0
frame_cnt_o  out  16  completed frames, wraps 0xFFFF->0
underflow_o  out  1  one-cycle pulse: stream pixel missing
busy_o  out  1  1 in any state other than IDLE

Behaviour:
- Reset (sync): state IDLE; fv_o, lv_o, pd_o, s_ready, underflow_o, busy_o, frame_cnt_o, row/col counters = 0. Reset mid-frame aborts: outputs 0 on the cycle after the reset edge, no frame count increment.
- All outputs registered. FSM: IDLE -> FV_LEAD -> LINE_ACTIVE -> (LINE_BLANK -> LINE_ACTIVE)* -> FV_TRAIL -> FRAME_BLANK -> FV_LEAD or IDLE.
- IDLE: fv_o=0. enable=1 sampled at edge N -> FV_LEAD, fv_o=1 from cycle N+1.
- FV_LEAD: FV_LEAD cycles, fv_o=1, lv_o=0. LINE_ACTIVE: exactly H_ACTIVE cycles lv_o=1, col 0..H_ACTIVE-1. LINE_BLANK: H_BLANK cycles, fv_o=1, lv_o=0; occurs after every line except the last. FV_TRAIL: FV_TRAIL cycles fv_o=1. FRAME_BLANK: V_BLANK cycles fv_o=0; frame_cnt_o increments on the fv_o 1->0 transition.
- fv_o high span = FV_LEAD + V_ACTIVE*H_ACTIVE + (V_ACTIVE-1)*H_BLANK + FV_TRAIL; frame period adds V_BLANK. No gaps inside a line.
- End of FRAME_BLANK: enable=1 -> FV_LEAD (back-to-back frames); enable=0 -> IDLE. Deasserting enable never truncates a frame in flight.
- pattern_sel captured on entry to FV_LEAD, held for the whole frame.
- Patterns (col,row 12-bit, zero at line/frame start): ramp pd_o=col[9:0]; vertical pd_o=row[9:0]; checker pd_o=(col[3]^row[3])?10'h3FF:10'h000. Ramp wraps at 1024.
- Stream mode: s_ready=1 exactly in the cycle before each lv_o=1 cycle (H_ACTIVE cycles per line, shifted one earlier), 0 otherwise and in pattern modes. s_ready&s_valid at edge E -> s_data on pd_o with lv_o=1 in cycle after E. s_ready&~s_valid -> that pixel pd_o=10'h000, underflow_o=1 same cycle; timing never stalls.
- pd_o forced 0 whenever lv_o=0.

Decomposition:
- Package cmos_video_tx_pkg: FSM state enum, PAT_STREAM/PAT_HRAMP/PAT_VRAMP/PAT_CHECK codes, counter width constant (12).
- One sub-module: cmos_pattern_gen (col, row, pattern_sel, stream pixel -> pixel value, combinational); the FSM/counters stay in cmos_video_tx.

Test Plan:
- Params H_ACTIVE=8,V_ACTIVE=4,H_BLANK=4,FV_LEAD=3,FV_TRAIL=2,V_BLANK=5, pattern 1, enable held -> fv_o high 49 cycles, low 5, period 54; four lv_o pulses of 8; pd_o 0..7 each line; frame_cnt_o 1 after first fv fall.
- Same params, pattern 3 -> line rows 0-3 all col[3]=0 so pd_o=0x000; rerun H_ACTIVE=16 -> cols 8-15 read 0x3FF.
- Pattern 0, s_valid=1 with incrementing s_data 0x100.. -> pd_o 0x100..0x107 line 0, s_ready count per frame =32, underflow_o never.
- Pattern 0, drop s_valid for col 5 of line 2 -> that pixel pd_o=0, underflow_o one pulse, lv_o still 8 cycles, following pixels continue from next accepted value.
- Deassert enable mid-frame -> frame completes fully (49 fv cycles), then IDLE, busy_o=0 after FRAME_BLANK; pattern_sel change mid-frame has no effect until next frame.
- Assert reset at LINE_ACTIVE col 3 -> next cycle fv_o=lv_o=pd_o=0, frame_cnt_o=0; preload frame_cnt to 0xFFFF via 65535 frames (or force) -> wraps to 0.
